// File: rtl/data_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder_if
// Purpose  : Core data-memory port bundle (address, write data, byte enables,
//            read data) shared between the core and its responder.
// Revision : 1.0 - initial release
// ============================================================================
interface data_mem_responder_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0]   data_mem_addr;
    logic [XLEN-1:0]   data_mem_wdata;
    logic [XLEN/8-1:0] data_mem_we;
    logic [XLEN-1:0]   data_mem_out;

    modport master (
        output data_mem_addr,
        output data_mem_wdata,
        output data_mem_we,
        input  data_mem_out
    );

    modport slave (
        input  data_mem_addr,
        input  data_mem_wdata,
        input  data_mem_we,
        output data_mem_out
    );
endinterface
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Purpose  : Data-memory responder: word RAM plus MMIO bank (GPIO, timer with
//            compare flag), registered read data with read-before-write.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
    parameter int              XLEN       = 32,
    parameter int              RAM_AWIDTH = 12,
    parameter logic [XLEN-1:0] MMIO_BASE  = 32'h8000_0000
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    data_mem_responder_if.slave  bus,
    output logic [XLEN-1:0]      gpio_out,
    output logic                 timer_irq
);
    localparam int LANES     = XLEN / 8;
    localparam int RAM_WORDS = 1 << RAM_AWIDTH;

    localparam logic [1:0] c_reg_gpio = 2'd0;
    localparam logic [1:0] c_reg_cnt  = 2'd1;
    localparam logic [1:0] c_reg_cmp  = 2'd2;
    localparam logic [1:0] c_reg_stat = 2'd3;

    logic [XLEN-1:0] mem [RAM_WORDS];

    logic [XLEN-1:0] r_ram_rdata;
    logic            r_ram_sel;
    logic [XLEN-1:0] r_mmio_rdata;
    logic [XLEN-1:0] r_gpio;
    logic [XLEN-1:0] r_cnt;
    logic [XLEN-1:0] r_cmp;
    logic            r_match;

    logic                  w_ram_hit;
    logic                  w_mmio_hit;
    logic [RAM_AWIDTH-1:0] w_ram_idx;
    logic [1:0]            w_reg_sel;
    logic                  w_any_we;
    logic                  w_wr_gpio;
    logic                  w_wr_cnt;
    logic                  w_wr_cmp;
    logic                  w_clr_match;
    logic                  w_set_match;
    logic [XLEN-1:0]       w_mmio_rdata;

    function automatic logic [XLEN-1:0] merge_lanes(
        input logic [XLEN-1:0]  old_val,
        input logic [XLEN-1:0]  new_val,
        input logic [LANES-1:0] lane_we
    );
        logic [XLEN-1:0] res;
        res = old_val;
        for (int l = 0; l < LANES; l++) begin
            if (lane_we[l]) res[8*l +: 8] = new_val[8*l +: 8];
        end
        return res;
    endfunction

    // Byte offset bits [1:0] are ignored by both decoders.
    assign w_ram_hit   = (bus.data_mem_addr >> (RAM_AWIDTH + 2)) == '0;
    assign w_mmio_hit  = bus.data_mem_addr[XLEN-1:4] == MMIO_BASE[XLEN-1:4];
    assign w_ram_idx   = bus.data_mem_addr[RAM_AWIDTH+1:2];
    assign w_reg_sel   = bus.data_mem_addr[3:2];
    assign w_any_we    = |bus.data_mem_we;

    assign w_wr_gpio   = w_mmio_hit && (w_reg_sel == c_reg_gpio) && w_any_we;
    assign w_wr_cnt    = w_mmio_hit && (w_reg_sel == c_reg_cnt)  && w_any_we;
    assign w_wr_cmp    = w_mmio_hit && (w_reg_sel == c_reg_cmp)  && w_any_we;
    assign w_clr_match = w_mmio_hit && (w_reg_sel == c_reg_stat)
                         && bus.data_mem_we[0] && bus.data_mem_wdata[0];
    assign w_set_match = (r_cnt == r_cmp);

    always_comb begin
        w_mmio_rdata = '0;
        if (w_mmio_hit) begin
            case (w_reg_sel)
                c_reg_gpio: w_mmio_rdata = r_gpio;
                c_reg_cnt:  w_mmio_rdata = r_cnt;
                c_reg_cmp:  w_mmio_rdata = r_cmp;
                default:    w_mmio_rdata = {{(XLEN-1){1'b0}}, r_match};
            endcase
        end
    end

    // RAM has no reset so it can map onto block memory; the old word is read.
    always_ff @(posedge clk) begin
        r_ram_rdata <= mem[w_ram_idx];
        for (int l = 0; l < LANES; l++) begin
            if (w_ram_hit && bus.data_mem_we[l]) begin
                mem[w_ram_idx][8*l +: 8] <= bus.data_mem_wdata[8*l +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ram_sel    <= 1'b0;
            r_mmio_rdata <= '0;
            r_gpio       <= '0;
            r_cnt        <= '0;
            r_cmp        <= '1;
            r_match      <= 1'b0;
        end else begin
            r_ram_sel    <= w_ram_hit;
            r_mmio_rdata <= w_mmio_rdata;
            if (w_wr_gpio) r_gpio <= merge_lanes(r_gpio, bus.data_mem_wdata, bus.data_mem_we);
            if (w_wr_cmp)  r_cmp  <= merge_lanes(r_cmp,  bus.data_mem_wdata, bus.data_mem_we);
            // Unwritten counter lanes hold their pre-increment value.
            if (w_wr_cnt)  r_cnt  <= merge_lanes(r_cnt,  bus.data_mem_wdata, bus.data_mem_we);
            else           r_cnt  <= r_cnt + 1'b1;
            if (w_set_match)      r_match <= 1'b1;
            else if (w_clr_match) r_match <= 1'b0;
        end
    end

    assign bus.data_mem_out = r_ram_sel ? r_ram_rdata : r_mmio_rdata;
    assign gpio_out         = r_gpio;
    assign timer_irq        = r_match;
endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_responder
// Purpose  : Self-checking bench for data_mem_responder with a transaction-level
//            reference model of the memory map and timer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;
    localparam logic [31:0] MMIO      = 32'h8000_0000;
    localparam logic [31:0] RAM_BYTES = 32'h0000_4000;
    localparam logic [31:0] IDLE      = 32'h8000_0010;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] gpio_out;
    logic        timer_irq;

    int errors = 0;
    int checks = 0;

    data_mem_responder_if #(.XLEN(32)) bus ();

    data_mem_responder #(
        .XLEN       (32),
        .RAM_AWIDTH (12),
        .MMIO_BASE  (MMIO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .gpio_out  (gpio_out),
        .timer_irq (timer_irq)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_ram [0:4095];
    logic [31:0] m_gpio, m_cnt, m_cmp, m_out;
    logic        m_match;

    function automatic logic [31:0] apply_lanes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  we);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) if (we[i]) r[8*i +: 8] = new_v[8*i +: 8];
        return r;
    endfunction

    function automatic logic is_mmio(input logic [31:0] a);
        return (a >= MMIO) && (a < MMIO + 32'd16);
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (a < RAM_BYTES) return m_ram[a[13:2]];
        if (is_mmio(a)) begin
            case (a[3:2])
                2'd0:    return m_gpio;
                2'd1:    return m_cnt;
                2'd2:    return m_cmp;
                default: return {31'd0, m_match};
            endcase
        end
        return 32'd0;
    endfunction

    task automatic model_reset();
        m_gpio = 0; m_cnt = 0; m_cmp = 32'hFFFF_FFFF; m_match = 0; m_out = 0;
    endtask

    // One bus cycle: drive on the falling edge, advance the model at the rising edge.
    task automatic cycle(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
        logic        set_c, clr_c;
        logic [31:0] nxt_cnt;
        @(negedge clk);
        bus.data_mem_addr  = a;
        bus.data_mem_wdata = d;
        bus.data_mem_we    = we;
        @(posedge clk);
        set_c   = (m_cnt == m_cmp);
        clr_c   = is_mmio(a) && (a[3:2] == 2'd3) && we[0] && d[0];
        m_out   = m_read(a);
        nxt_cnt = m_cnt + 32'd1;
        if (a < RAM_BYTES) m_ram[a[13:2]] = apply_lanes(m_ram[a[13:2]], d, we);
        else if (is_mmio(a)) begin
            case (a[3:2])
                2'd0: m_gpio = apply_lanes(m_gpio, d, we);
                2'd1: if (we != 4'd0) nxt_cnt = apply_lanes(m_cnt, d, we);
                2'd2: m_cmp = apply_lanes(m_cmp, d, we);
                default: ;
            endcase
        end
        m_cnt   = nxt_cnt;
        m_match = set_c | (m_match & ~clr_c);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.data_mem_addr = IDLE; bus.data_mem_wdata = 0; bus.data_mem_we = 0;
        repeat (2) @(posedge clk);
        #2;
        if (bus.data_mem_out !== 32'd0) begin errors++; $display("FAIL reset_out: got %h want %h", bus.data_mem_out, 32'd0); end
        checks++;
        if (gpio_out !== 32'd0) begin errors++; $display("FAIL reset_gpio: got %h want %h", gpio_out, 32'd0); end
        checks++;
        if (timer_irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", timer_irq); end
        checks++;
        rst_n = 1'b1;
        model_reset();
        cycle(MMIO + 32'h8, 0, 0);
        if (bus.data_mem_out !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_cmp: got %h want %h", bus.data_mem_out, 32'hFFFF_FFFF); end
        checks++;
        cycle(MMIO + 32'hC, 0, 0);
        if (bus.data_mem_out !== 32'd0) begin errors++; $display("FAIL reset_stat: got %h want %h", bus.data_mem_out, 32'd0); end
        checks++;
    endtask

    task automatic test_ram();
        cycle(32'h10, 32'hDEAD_BEEF, 4'hF);
        cycle(32'h10, 0, 4'h0);
        if (bus.data_mem_out !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_read: got %h want %h", bus.data_mem_out, 32'hDEAD_BEEF); end
        checks++;
    endtask

    task automatic test_byte_lanes();
        cycle(32'h10, 32'h0000_5500, 4'b0010);
        if (bus.data_mem_out !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rbw_old: got %h want %h", bus.data_mem_out, 32'hDEAD_BEEF); end
        checks++;
        cycle(32'h13, 0, 4'h0);
        if (bus.data_mem_out !== 32'hDEAD_55EF) begin errors++; $display("FAIL lane_merge: got %h want %h", bus.data_mem_out, 32'hDEAD_55EF); end
        checks++;
    endtask

    task automatic test_gpio_unmapped();
        cycle(MMIO, 32'h1234_5678, 4'hF);
        if (gpio_out !== 32'h1234_5678) begin errors++; $display("FAIL gpio_write: got %h want %h", gpio_out, 32'h1234_5678); end
        checks++;
        cycle(MMIO + 32'h10, 32'hFFFF_FFFF, 4'hF);
        if (bus.data_mem_out !== 32'd0) begin errors++; $display("FAIL unmapped_read: got %h want %h", bus.data_mem_out, 32'd0); end
        checks++;
        cycle(MMIO, 0, 4'h0);
        if (bus.data_mem_out !== 32'h1234_5678 || gpio_out !== 32'h1234_5678) begin
            errors++; $display("FAIL unmapped_write: got %h/%h want %h", bus.data_mem_out, gpio_out, 32'h1234_5678);
        end
        checks++;
    endtask

    task automatic test_timer();
        cycle(MMIO + 32'h4, 32'hFFFF_FFFE, 4'hF);
        cycle(MMIO + 32'h8, 32'h0000_0001, 4'hF);
        cycle(MMIO + 32'h4, 0, 0);
        if (bus.data_mem_out !== 32'hFFFF_FFFF || timer_irq !== 1'b0) begin
            errors++; $display("FAIL timer_ffff: got %h irq %b want %h irq 0", bus.data_mem_out, timer_irq, 32'hFFFF_FFFF);
        end
        checks++;
        cycle(MMIO + 32'h4, 0, 0);
        if (bus.data_mem_out !== 32'd0 || timer_irq !== 1'b0) begin
            errors++; $display("FAIL timer_wrap: got %h irq %b want 0 irq 0", bus.data_mem_out, timer_irq);
        end
        checks++;
        cycle(MMIO + 32'h4, 0, 0);
        if (bus.data_mem_out !== 32'd1 || timer_irq !== 1'b1) begin
            errors++; $display("FAIL timer_match: got %h irq %b want 1 irq 1", bus.data_mem_out, timer_irq);
        end
        checks++;
    endtask

    task automatic test_w1c();
        cycle(MMIO + 32'hC, 32'h1, 4'b0001);
        if (timer_irq !== 1'b0) begin errors++; $display("FAIL w1c_clear: got %b want 0", timer_irq); end
        checks++;
        cycle(MMIO + 32'h4, 32'h1, 4'hF);
        cycle(IDLE, 0, 0);
        if (timer_irq !== 1'b1) begin errors++; $display("FAIL w1c_reset_match: got %b want 1", timer_irq); end
        checks++;
        cycle(MMIO + 32'h4, 32'h1, 4'hF);
        cycle(MMIO + 32'hC, 32'h1, 4'b0001);
        if (timer_irq !== 1'b1) begin errors++; $display("FAIL w1c_race: got %b want 1", timer_irq); end
        checks++;
        cycle(MMIO + 32'hC, 32'hFFFF_FFFE, 4'hF);
        if (timer_irq !== 1'b1) begin errors++; $display("FAIL w1c_bit0_zero: got %b want 1", timer_irq); end
        checks++;
        cycle(MMIO + 32'hC, 32'h1, 4'b0001);
        if (timer_irq !== 1'b0) begin errors++; $display("FAIL w1c_clear2: got %b want 0", timer_irq); end
        checks++;
    endtask

    task automatic test_random();
        logic [31:0] a, d;
        logic [3:0]  we;
        int          pick;
        for (int w = 0; w < 16; w++) cycle(w * 4, $urandom, 4'hF);
        for (int n = 0; n < 300; n++) begin
            pick = $urandom_range(0, 11);
            d    = $urandom;
            we   = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
            if (pick < 6)       a = 32'($urandom_range(0, 15)) * 4;
            else if (pick < 9)  a = MMIO + 32'($urandom_range(0, 3)) * 4;
            else if (pick == 9) begin a = MMIO + 32'h8; d = m_cnt + 32'($urandom_range(1, 4)); we = 4'hF; end
            else begin
                case ($urandom_range(0, 3))
                    0: a = RAM_BYTES;
                    1: a = IDLE;
                    2: a = 32'h7FFF_FFFC;
                    default: a = 32'hFFFF_FFFC;
                endcase
            end
            a[1:0] = 2'($urandom);
            cycle(a, d, we);
            if (bus.data_mem_out !== m_out) begin errors++; $display("FAIL rand_out[%0d]: addr %h got %h want %h", n, a, bus.data_mem_out, m_out); end
            checks++;
            if (gpio_out !== m_gpio) begin errors++; $display("FAIL rand_gpio[%0d]: got %h want %h", n, gpio_out, m_gpio); end
            checks++;
            if (timer_irq !== m_match) begin errors++; $display("FAIL rand_irq[%0d]: got %b want %b", n, timer_irq, m_match); end
            checks++;
        end
    endtask

    task automatic test_async_reset();
        cycle(MMIO, 32'h0F0F_0F0F, 4'hF);
        cycle(MMIO + 32'h8, 32'h5, 4'hF);
        cycle(MMIO + 32'h4, 32'h5, 4'hF);
        cycle(MMIO, 0, 0);
        if (timer_irq !== 1'b1 || gpio_out !== 32'h0F0F_0F0F) begin
            errors++; $display("FAIL pre_reset: irq %b gpio %h want 1 %h", timer_irq, gpio_out, 32'h0F0F_0F0F);
        end
        checks++;
        @(negedge clk);
        bus.data_mem_addr = MMIO; bus.data_mem_wdata = 32'hAAAA_AAAA; bus.data_mem_we = 4'hF;
        #2 rst_n = 1'b0;
        #1;
        if (gpio_out !== 32'd0 || timer_irq !== 1'b0 || bus.data_mem_out !== 32'd0) begin
            errors++; $display("FAIL async_reset: gpio %h irq %b out %h want 0 0 0", gpio_out, timer_irq, bus.data_mem_out);
        end
        checks++;
        @(posedge clk);
        #2 rst_n = 1'b1;
        model_reset();
        cycle(MMIO + 32'h4, 0, 0);
        if (bus.data_mem_out !== 32'd0) begin errors++; $display("FAIL cnt_after_reset: got %h want 0", bus.data_mem_out); end
        checks++;
        cycle(MMIO + 32'h4, 0, 0);
        if (bus.data_mem_out !== 32'd1 || gpio_out !== 32'd0) begin
            errors++; $display("FAIL cnt_run_after_reset: got %h gpio %h want 1 0", bus.data_mem_out, gpio_out);
        end
        checks++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ram();
        test_byte_lanes();
        test_gpio_unmapped();
        test_timer();
        test_w1c();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
